// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider, 64b dividend / 32b divisor -> 32b quotient + 32b remainder.
// Latency: 34 cycles from acceptance to out_valid (1 cycle for divide-by-zero / early overflow).
// Backpressure: single operation in flight; in_ready low while busy, result held until out_ready.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready     operand handshake; in_ready is high only in IDLE
//   dividend[63:0]          dividend
//   divisor[31:0]           divisor
//   out_valid / out_ready   result handshake; out_valid held until out_ready
//   quotient[31:0]          truncated quotient
//   remainder[31:0]         remainder (sign follows the dividend in the signed build)
//   div_zero, ovf           divisor was zero / quotient does not fit in 32 bits
//
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands;
// without it, operands are treated as unsigned.

module seq_divider #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int              CW   = $clog2(ITER);
  localparam logic [CW-1:0]   LAST = CW'(ITER - 1);

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [31:0] OVF_QUO = 32'h8000_0000;
`else
  localparam logic [31:0] OVF_QUO = 32'hFFFF_FFFF;
`endif

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  // rem: partial remainder (always < divisor, so 32 bits hold it between steps)
  // quo: low dividend word shifting out the top while quotient bits shift in below
  logic [31:0]    rem_q, rem_d;
  logic [31:0]    quo_q, quo_d;
  logic [31:0]    dvs_q, dvs_d;
  logic [31:0]    quotient_q, quotient_d;
  logic [31:0]    remainder_q, remainder_d;
  logic           div_zero_q, div_zero_d;
  logic           ovf_q, ovf_d;
  logic           out_valid_q, out_valid_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
  // Result sign flags: quotient negative if operand signs differ, remainder follows dividend.
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
`endif

  logic [63:0]    mag_dvd;
  logic [31:0]    mag_dvs;
  logic [32:0]    shifted;
  logic           ge;

  always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    mag_dvd = dividend[63] ? (~dividend + 64'd1) : dividend;
    mag_dvs = divisor[31]  ? (~divisor + 32'd1)  : divisor;
`else
    mag_dvd = dividend;
    mag_dvs = divisor;
`endif
    // One restoring step: bring in the next dividend bit, then trial-subtract.
    shifted = {rem_q, quo_q[31]};
    ge      = (shifted >= {1'b0, dvs_q});
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor == 32'd0) begin
            state_d     = DONE;
            div_zero_d  = 1'b1;
            ovf_d       = 1'b0;
            quotient_d  = 32'hFFFF_FFFF;
            remainder_d = dividend[31:0];
          end else if (mag_dvd[63:32] >= mag_dvs) begin
            // High word already >= divisor: quotient cannot fit, skip iteration.
            state_d     = DONE;
            div_zero_d  = 1'b0;
            ovf_d       = 1'b1;
            quotient_d  = OVF_QUO;
            remainder_d = 32'd0;
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            rem_d   = mag_dvd[63:32];
            quo_d   = mag_dvd[31:0];
            dvs_d   = mag_dvs;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quo_d = dividend[63] ^ divisor[31];
            neg_rem_d = dividend[63];
`endif
          end
        end
      end

      CALC: begin
        // When ge, shifted - dvs < dvs, so the low 32 bits of the difference are exact.
        rem_d = ge ? (shifted[31:0] - dvs_q) : shifted[31:0];
        quo_d = {quo_q[30:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = FIX;
        end
      end

      FIX: begin
        state_d    = DONE;
        div_zero_d = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        // Magnitude may be 2^31 only when the result is negative.
        if (neg_quo_q ? (quo_q > 32'h8000_0000) : (quo_q > 32'h7FFF_FFFF)) begin
          ovf_d       = 1'b1;
          quotient_d  = 32'h8000_0000;
          remainder_d = 32'd0;
        end else begin
          ovf_d       = 1'b0;
          quotient_d  = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
          remainder_d = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
        end
`else
        ovf_d       = 1'b0;
        quotient_d  = quo_q;
        remainder_d = rem_q;
`endif
      end

      DONE: begin
        // out_valid rises one cycle after entering DONE and drops on the accepting edge.
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign ovf       = ovf_q;

endmodule
